// File: rtl/enc_menu_ctrl.sv
// Rotary-encoder menu controller: browse/edit/lock state machine over four 8-bit
// parameter registers, with a commit strobe and an inactivity timeout in edit.
module enc_menu_ctrl #(
  parameter int unsigned TIMEOUT = 5000,
  parameter logic [7:0]  DEF0    = 8'h00,
  parameter logic [7:0]  DEF1    = 8'h00,
  parameter logic [7:0]  DEF2    = 8'h00,
  parameter logic [7:0]  DEF3    = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  enc,
  input  logic        press_valid,
  input  logic [1:0]  press_type,
  output logic [1:0]  mode,
  output logic [1:0]  sel,
  output logic [7:0]  edit_val,
  output logic [31:0] params,
  output logic        cfg_wr,
  output logic [1:0]  cfg_addr,
  output logic [7:0]  cfg_data
);

  typedef enum logic [1:0] {
    StBrowse = 2'b00,
    StEdit   = 2'b01,
    StLocked = 2'b10
  } state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [3:0]      enc_last_q;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      work_q, work_d;
  logic [15:0]     timer_q, timer_d;
  logic [3:0][7:0] params_q, params_d;
  logic            cfg_wr_q, cfg_wr_d;
  logic [1:0]      cfg_addr_q, cfg_addr_d;
  logic [7:0]      cfg_data_q, cfg_data_d;

  logic [3:0] delta;
  logic       moved, press, is_short, is_long;
  logic [9:0] work_sum;
  logic [7:0] work_sat;

  // Encoder difference read as 4-bit two's complement, so wrap-around steps stay small.
  assign delta    = enc - enc_last_q;
  assign moved    = (delta != 4'd0);
  assign press    = press_valid && (press_type != 2'b00);
  assign is_short = press && (press_type == 2'b01);
  assign is_long  = press && (press_type == 2'b11);

  assign work_sum = {2'b00, work_q} + {{6{delta[3]}}, delta};
  always_comb begin
    work_sat = work_sum[7:0];
    if (work_sum[9])      work_sat = 8'h00;
    else if (work_sum[8]) work_sat = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= StBrowse;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    work_d     = work_q;
    timer_d    = timer_q;
    params_d   = params_q;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    unique case (state_q)
      StBrowse: begin
        if (is_short) begin
          work_d  = params_q[sel_q];
          timer_d = '0;
          state_d = StEdit;
        end else if (is_long) begin
          state_d = StLocked;
        end else if (!press && moved) begin
          sel_d = sel_q + delta[1:0];
        end
      end
      StEdit: begin
        if (is_short) begin
          params_d[sel_q] = work_q;
          cfg_wr_d        = 1'b1;
          cfg_addr_d      = sel_q;
          cfg_data_d      = work_q;
          state_d         = StBrowse;
        end else if (press) begin
          state_d = StBrowse;
        end else if (moved) begin
          work_d  = work_sat;
          timer_d = '0;
        end else if (timer_q == TimerLast) begin
          state_d = StBrowse;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StLocked: begin
        if (is_long) state_d = StBrowse;
      end
      default: state_d = StBrowse;
    endcase
  end

  // enc_last tracks enc even during reset so the first live cycle sees no motion.
  always_ff @(posedge clk) begin
    enc_last_q <= enc;
    if (!rstn) begin
      sel_q      <= 2'd0;
      work_q     <= 8'd0;
      timer_q    <= 16'd0;
      params_q   <= {DEF3, DEF2, DEF1, DEF0};
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= 2'd0;
      cfg_data_q <= 8'd0;
    end else begin
      sel_q      <= sel_d;
      work_q     <= work_d;
      timer_q    <= timer_d;
      params_q   <= params_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  always_comb begin
    mode     = state_q;
    sel      = sel_q;
    params   = params_q;
    cfg_wr   = cfg_wr_q;
    cfg_addr = cfg_addr_q;
    cfg_data = cfg_data_q;
    edit_val = (state_q == StEdit) ? work_q : params_q[sel_q];
  end

endmodule
